// File: rtl/obi_reg_bridge.sv
// OBI slave to simple valid/ready register bus bridge with one transaction outstanding,
// an access timeout and a saturating count of error responses.
module obi_reg_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ERRCNT_W       = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   output logic                gnt_o,
   input  logic [31:0]         addr_i,
   input  logic                we_i,
   input  logic [3:0]          be_i,
   input  logic [31:0]         wdata_i,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   output logic                err_o,
   output logic                reg_valid_o,
   output logic                reg_write_o,
   output logic [31:0]         reg_addr_o,
   output logic [31:0]         reg_wdata_o,
   output logic [3:0]          reg_wstrb_o,
   input  logic                reg_ready_i,
   input  logic [31:0]         reg_rdata_i,
   input  logic                reg_error_i,
   output logic [ERRCNT_W-1:0] err_count_o,
   output logic [1:0]          dbg_state_o
);

   // Handshake: OBI request is accepted when req_i && gnt_o at a rising edge; the
   // register bus holds reg_valid_o with stable fields until reg_ready_i is sampled high.
   localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [31:2]         addr_q, addr_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      errcnt_d = errcnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               if (be_i != 4'b0000) begin
                  addr_d  = addr_i[31:2];
                  we_d    = we_i;
                  be_d    = be_i;
                  wdata_d = wdata_i;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  // Empty byte mask: answer immediately without touching the register bus.
                  rdata_d = '0;
                  err_d   = 1'b0;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            if (reg_ready_i) begin
               rdata_d = we_q ? 32'h0 : reg_rdata_i;
               err_d   = reg_error_i;
               state_d = RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            if (err_q && (errcnt_q != {ERRCNT_W{1'b1}})) begin
               errcnt_d = errcnt_q + ERRCNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o       = (state_q == IDLE) && req_i;
   assign rvalid_o    = (state_q == RESP);
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign reg_valid_o = (state_q == ACCESS);
   assign reg_write_o = we_q;
   assign reg_addr_o  = {addr_q, 2'b00};
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = be_q;
   assign err_count_o = errcnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/obi_reg_bridge.md
OBI_REG_BRIDGE -- requirements
Module: obi_reg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in ACCESS awaiting reg_ready_i; 0 disables timeout.
REQ-002 SHALL have parameter ERRCNT_W, default 16, width of saturating error counter.
REQ-003 SHALL provide clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL provide req_i  in  1  OBI request valid.
REQ-006 SHALL provide gnt_o  out  1  OBI grant.
REQ-007 SHALL provide addr_i  in  32  OBI byte address.
REQ-008 SHALL provide we_i  in  1  OBI write enable (1 = write).
REQ-009 SHALL provide be_i  in  4  OBI byte enables.
REQ-010 SHALL provide wdata_i  in  32  OBI write data.
REQ-011 SHALL provide rvalid_o  out  1  OBI response valid, one-cycle pulse.
REQ-012 SHALL provide rdata_o  out  32  OBI read data, valid with rvalid_o.
REQ-013 SHALL provide err_o  out  1  OBI response error, valid with rvalid_o.
REQ-014 SHALL provide reg_valid_o  out  1  register-bus request valid.
REQ-015 SHALL provide reg_write_o  out  1  register-bus write.
REQ-016 SHALL provide reg_addr_o  out  32  word-aligned register address.
REQ-017 SHALL provide reg_wdata_o  out  32  register write data.
REQ-018 SHALL provide reg_wstrb_o  out  4  register write strobes.
REQ-019 SHALL provide reg_ready_i  in  1  register-bus completion.
REQ-020 SHALL provide reg_rdata_i  in  32  register read data, sampled with reg_ready_i.
REQ-021 SHALL provide reg_error_i  in  1  register-bus error, sampled with reg_ready_i.
REQ-022 SHALL provide err_count_o  out  ERRCNT_W  count of error responses, saturating.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction outstanding.
REQ-024 SHALL assert gnt_o = req_i only in IDLE (combinational); gnt_o = 0 in ACCESS and RESP.
REQ-025 On grant with be_i != 0: SHALL register addr/we/be/wdata, go to ACCESS next cycle.
REQ-026 On grant with be_i == 0: SHALL skip bus access, go to RESP with rdata_o = 0, err_o = 0.
REQ-027 In ACCESS SHALL drive reg_valid_o = 1 with stable registered fields; reg_addr_o = {addr[31:2],2'b00}; reg_wstrb_o = be; reg_write_o = we.
REQ-028 reg_valid_o SHALL stay high until the cycle reg_ready_i = 1 (inclusive), then deassert next cycle.
REQ-029 On reg_ready_i in ACCESS: SHALL go to RESP, capture rdata_o = reg_rdata_i for reads, 0 for writes; err_o = reg_error_i.
REQ-030 Timeout: counter clears on ACCESS entry, increments each ACCESS cycle without reg_ready_i; reaching TIMEOUT_CYCLES SHALL abort (reg_valid_o low next cycle), go to RESP with err_o = 1, rdata_o = 0.
REQ-031 reg_ready_i in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal completion, no timeout error.
REQ-032 RESP SHALL last exactly one cycle with rvalid_o = 1, then return to IDLE; rdata_o/err_o SHALL hold until next response.
REQ-033 Latency: grant at cycle T, reg_valid_o from T+1, reg_ready_i at T+k (k>=1), rvalid_o at T+k+1; be==0 case rvalid_o at T+1.
REQ-034 Back-to-back: a new request SHALL be granted no earlier than the cycle after RESP.
REQ-035 err_count_o SHALL increment by 1 on each rvalid_o with err_o = 1, saturating at all-ones.
REQ-036 reg_ready_i outside ACCESS SHALL be ignored.

Reset
REQ-037 rst_i high at a clock edge SHALL force IDLE, and gnt_o(registered part)/rvalid_o/reg_valid_o/err_o = 0, rdata_o = 0, err_count_o = 0, timeout counter = 0.
REQ-038 Reset mid-ACCESS or mid-RESP SHALL abandon the transaction with no response pulse; reg_valid_o low the cycle after reset is sampled.

Verification
REQ-039 Read: addr 0x2000_0006, be 0xF, reg_ready_i 2 cycles after reg_valid_o with rdata 0xDEAD_BEEF -> reg_addr_o 0x2000_0004, rvalid_o one cycle later, rdata_o 0xDEAD_BEEF, err_o 0.
REQ-040 Write: wdata 0x1234_5678, be 0x3, immediate ready -> reg_write_o 1, reg_wstrb_o 0x3, rvalid_o at T+2, rdata_o 0.
REQ-041 Timeout: TIMEOUT_CYCLES=4, reg_ready_i never -> reg_valid_o high 4 cycles, err_o 1, err_count_o 1.
REQ-042 Race: reg_ready_i on timeout cycle with reg_error_i 0 -> err_o 0, err_count_o unchanged.
REQ-043 be_i = 0 request -> no reg_valid_o, rvalid_o at T+1, err_o 0.
REQ-044 rst_i during ACCESS -> no rvalid_o, IDLE, new request granted after reset released.
